// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: runs one req/ready data-memory transaction per access,
// generating byte enables and store lanes, extending loads, and faulting on misalignment or timeout.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        req;
    logic        f3_legal;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_rep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    assign req   = memread | memwrite;
    assign stall = ((state == IDLE) && req) || (state == BUS);

    always_comb begin
        f3_legal   = 1'b0;
        be_next    = 4'b1111;
        wdata_rep  = wdata;
        // Both memread and memwrite set is treated as a read.
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = memread;
            default:                f3_legal = 1'b0;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_next   = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next   = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be_next   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'b00:   lane_b = bus_rdata[7:0];
            2'b01:   lane_b = bus_rdata[15:8];
            2'b10:   lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            rdata     <= 32'h0;
            done      <= 1'b0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (f3_legal && !misaligned) begin
                            state     <= BUS;
                            cnt       <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= !memread;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= be_next;
                            bus_wdata <= wdata_rep;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            rdata <= 32'h0;
                        end
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        if (!bus_we)
                            rdata <= load_ext;
                        state   <= DONE;
                        done    <= 1'b1;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                        rdata   <= 32'h0;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: table of load/store accesses with hand-computed
// results, plus reset, idle-ready and mid-transaction reset sequences.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        memread, memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .done(done), .fault(fault), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, brdata;
        int          dly;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        int          exp_stalls, exp_reqs;
        logic        exp_we;
        logic [31:0] exp_baddr;
        logic [3:0]  exp_be;
        logic        chk_wdata;
        logic [31:0] exp_bwdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] brd, input int dly,
                                input logic ef, input logic [31:0] er,
                                input int es, input int eq, input logic ewe,
                                input logic [31:0] eba, input logic [3:0] ebe,
                                input logic cw, input logic [31:0] ebw);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.brdata = brd;
        v.dly = dly; v.exp_fault = ef; v.exp_rdata = er; v.exp_stalls = es;
        v.exp_reqs = eq; v.exp_we = ewe; v.exp_baddr = eba; v.exp_be = ebe;
        v.chk_wdata = cw; v.exp_bwdata = ebw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run(input int idx, input vec_t v);
        int  stalls = 0;
        int  reqs   = 0;
        int  waits  = 0;
        bit  got_done = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        memread = v.rd; memwrite = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1;
        for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
            if (stall) stalls++;
            if (done) begin
                got_done = 1;
                memread = 1'b0; memwrite = 1'b0; bus_ready = 1'b0;
                chk({tag, " fault"}, {31'h0, fault}, {31'h0, v.exp_fault});
                chk({tag, " rdata"}, rdata, v.exp_rdata);
            end else begin
                if (bus_req) begin
                    if (reqs == 0) begin
                        chk({tag, " bus_addr"}, bus_addr, v.exp_baddr);
                        chk({tag, " bus_be"}, {28'h0, bus_be}, {28'h0, v.exp_be});
                        chk({tag, " bus_we"}, {31'h0, bus_we}, {31'h0, v.exp_we});
                        if (v.chk_wdata) chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
                    end
                    reqs++;
                    bus_ready = (waits == v.dly);
                    bus_rdata = v.brdata;
                    waits++;
                end else begin
                    bus_ready = 1'b0;
                end
                @(negedge clk); #1;
            end
        end
        chk({tag, " done_seen"}, {31'h0, got_done}, 32'h1);
        chk({tag, " stall_cycles"}, stalls, v.exp_stalls);
        chk({tag, " req_cycles"}, reqs, v.exp_reqs);
        @(negedge clk); #1;
        chk({tag, " done_one_cycle"}, {31'h0, done}, 32'h0);
    endtask

    vec_t vecs[16];

    initial begin
        int dones;
        vecs[0]  = mk(1,0,3'b010,32'h100,32'h0,32'hDEADBEEF,0, 0,32'hDEADBEEF,2,1,0,32'h100,4'hF,0,32'h0);
        vecs[1]  = mk(1,0,3'b000,32'h103,32'h0,32'h80FF0000,0, 0,32'hFFFFFF80,2,1,0,32'h100,4'h8,0,32'h0);
        vecs[2]  = mk(1,0,3'b100,32'h103,32'h0,32'h80FF0000,0, 0,32'h00000080,2,1,0,32'h100,4'h8,0,32'h0);
        vecs[3]  = mk(0,1,3'b001,32'h202,32'h1234ABCD,32'h0,3, 0,32'h00000080,5,4,1,32'h200,4'hC,1,32'hABCDABCD);
        vecs[4]  = mk(1,0,3'b010,32'h101,32'h0,32'h0,0, 1,32'h0,1,0,0,32'h0,4'h0,0,32'h0);
        vecs[5]  = mk(1,0,3'b001,32'h102,32'h0,32'h80011234,1, 0,32'hFFFF8001,3,2,0,32'h100,4'hC,0,32'h0);
        vecs[6]  = mk(0,1,3'b001,32'h3,32'h5555,32'h0,0, 1,32'h0,1,0,0,32'h0,4'h0,0,32'h0);
        vecs[7]  = mk(1,0,3'b101,32'h100,32'h0,32'h12349ABC,0, 0,32'h00009ABC,2,1,0,32'h100,4'h3,0,32'h0);
        vecs[8]  = mk(1,0,3'b011,32'h0,32'h0,32'h0,0, 1,32'h0,1,0,0,32'h0,4'h0,0,32'h0);
        vecs[9]  = mk(1,0,3'b010,32'h44,32'h0,32'h0BADF00D,2, 0,32'h0BADF00D,4,3,0,32'h44,4'hF,0,32'h0);
        vecs[10] = mk(0,1,3'b000,32'h101,32'hA5,32'h0,0, 0,32'h0BADF00D,2,1,1,32'h100,4'h2,1,32'hA5A5A5A5);
        vecs[11] = mk(0,1,3'b010,32'h8,32'h11223344,32'h0,1, 0,32'h0BADF00D,3,2,1,32'h8,4'hF,1,32'h11223344);
        vecs[12] = mk(1,0,3'b010,32'h20,32'h0,32'hFFFFFFFF,99, 1,32'h0,5,4,0,32'h20,4'hF,0,32'h0);
        vecs[13] = mk(1,1,3'b000,32'h2,32'h0,32'h00550000,0, 0,32'h00000055,2,1,0,32'h0,4'h4,0,32'h0);
        vecs[14] = mk(0,1,3'b100,32'h0,32'h0,32'h0,0, 1,32'h0,1,0,0,32'h0,4'h0,0,32'h0);
        vecs[15] = mk(1,0,3'b000,32'h10,32'h0,32'h0000007F,0, 0,32'h0000007F,2,1,0,32'h10,4'h1,0,32'h0);

        rst = 1'b1; memread = 0; memwrite = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {rdata, bus_addr, bus_wdata},
            {32'h0, 32'h0, 32'h0});
        chk("reset ctrl", {26'h0, done, fault, bus_req, bus_we, stall, 1'b0},
            32'h0);
        chk("reset be", {28'h0, bus_be}, 32'h0);
        rst = 1'b0;

        // bus_ready while idle must not complete anything.
        dones = 0;
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done || bus_req) dones++;
        end
        bus_ready = 1'b0;
        chk("idle ready ignored", dones, 0);
        chk("idle ready rdata", rdata, 32'h0);

        for (int i = 0; i < 16; i++) run(i, vecs[i]);

        chk("hold bus_addr", bus_addr, 32'h10);
        chk("hold bus_be", {28'h0, bus_be}, 32'h1);
        chk("idle bus_req/we", {30'h0, bus_req, bus_we}, 32'h0);

        // Reset during the second BUS cycle of a store.
        @(negedge clk);
        memwrite = 1'b1; funct3 = 3'b010; addr = 32'h300; wdata = 32'hCAFEF00D;
        @(negedge clk); #1;
        chk("rst seq bus_req cyc1", {31'h0, bus_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1; memwrite = 1'b0;
        @(negedge clk); #1;
        chk("rst seq ctrl", {27'h0, done, fault, bus_req, bus_we, stall}, 32'h0);
        chk("rst seq addr", bus_addr, 32'h0);
        chk("rst seq wdata", bus_wdata, 32'h0);
        chk("rst seq be", {28'h0, bus_be}, 32'h0);
        chk("rst seq rdata", rdata, 32'h0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (done || bus_req) dones++;
        end
        chk("rst seq no done", dones, 0);
        run(100, vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
